// File: rtl/cbus_arbiter_if.sv
// CBus request/response types and the grouped arbiter port interface
// (upstream request/response arrays plus the single downstream port).
package cbus_pkg;
   localparam logic [3:0] MLEN16 = 4'd15;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [3:0]  len;
      logic [1:0]  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;
endpackage

interface cbus_arbiter_if #(parameter int NUM_MASTERS = 2);
   import cbus_pkg::*;

   cbus_req_t  ireqs  [NUM_MASTERS];
   cbus_resp_t iresps [NUM_MASTERS];
   cbus_req_t  oreq;
   cbus_resp_t oresp;

   modport slave  (input ireqs, input oresp, output iresps, output oreq);
   modport master (output ireqs, output oresp, input iresps, input oreq);
endinterface

// File: rtl/cbus_arbiter.sv
// CBus arbiter: holds a grant for a whole burst, releases on ready && last.
// Define CBUS_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module cbus_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_MASTERS = 2
) (
   input  logic           clk,
   input  logic           reset,
   cbus_arbiter_if.slave  bus
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   logic          busy_q, busy_d;
   logic [IW-1:0] index_q, index_d;
   logic          any_valid;
   logic [IW-1:0] winner;
   logic          burst_done;

   assign burst_done = bus.oresp.ready && bus.oresp.last;

`ifdef CBUS_ARB_RR_EN
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;

   // Scan from farthest to nearest after rr_ptr so the nearest valid master wins.
   always_comb begin
      int cand;
      any_valid = 1'b0;
      winner    = '0;
      cand      = 0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         cand = (int'(rr_ptr_q) + k) % NUM_MASTERS;
         if (bus.ireqs[cand].valid) begin
            any_valid = 1'b1;
            winner    = IW'(cand);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (busy_q == ST_BUSY && burst_done)
         rr_ptr_d = index_q;
   end

   always_ff @(posedge clk) begin
      if (reset)
         rr_ptr_q <= IW'(NUM_MASTERS - 1);
      else
         rr_ptr_q <= rr_ptr_d;
   end
`else
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      for (int m = NUM_MASTERS - 1; m >= 0; m--) begin
         if (bus.ireqs[m].valid) begin
            any_valid = 1'b1;
            winner    = IW'(m);
         end
      end
   end
`endif

   always_comb begin
      busy_d  = busy_q;
      index_d = index_q;
      case (busy_q)
         ST_IDLE: begin
            if (any_valid) begin
               busy_d  = ST_BUSY;
               index_d = winner;
            end
         end
         default: begin
            if (burst_done)
               busy_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q  <= ST_IDLE;
         index_q <= '0;
      end else begin
         busy_q  <= busy_d;
         index_q <= index_d;
      end
   end

   // Outputs depend only on registered grant plus live bus data, never on other requests.
   always_comb begin
      bus.oreq = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         bus.iresps[i] = '0;
      if (busy_q == ST_BUSY) begin
         bus.oreq            = bus.ireqs[index_q];
         bus.iresps[index_q] = bus.oresp;
      end
   end

   granted_valid_held: assert property (@(posedge clk) disable iff (reset)
      (busy_q == ST_BUSY) |-> bus.ireqs[index_q].valid);

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed bursts plus random traffic
// compared every cycle against a grant-ownership reference model.
module tb_cbus_arbiter;
   import cbus_pkg::*;

   localparam int N = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cbus_arbiter_if #(.NUM_MASTERS(N)) bus ();

   cbus_arbiter #(.NUM_MASTERS(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   cbus_req_t  reqs [N];
   cbus_resp_t resp;
   int owner, last_grant, ds_beat;
   int rx_beats [N];
   int done [N];
   int wait_mode, keep_alive, rand_mode, force_last_stall, prev_valid;
   int grant_log [$];
   int compared   = 0;
   int mismatched = 0;

   task automatic checkEq(string tag, logic [127:0] got, logic [127:0] want);
      compared++;
      assert (got === want) else begin
         mismatched++;
         $error("[TB] FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Reference selection: fixed lowest-index, or first valid after the last granted master.
   function automatic int pick();
`ifdef CBUS_ARB_RR_EN
      for (int k = 1; k <= N; k++)
         if (reqs[(last_grant + k) % N].valid) return (last_grant + k) % N;
`else
      for (int m = 0; m < N; m++)
         if (reqs[m].valid) return m;
`endif
      return -1;
   endfunction

   function automatic int lastGrant();
      if (grant_log.size() == 0) return -2;
      return grant_log[grant_log.size() - 1];
   endfunction

   task automatic newRequest(int m, logic wr, logic [31:0] addr, logic [3:0] len);
      reqs[m].valid    = 1'b1;
      reqs[m].is_write = wr;
      reqs[m].size     = 3'd3;
      reqs[m].addr     = addr;
      reqs[m].strobe   = wr ? 8'hFF : 8'h00;
      reqs[m].data     = wr ? {$urandom, $urandom} : 64'h0;
      reqs[m].len      = len;
      reqs[m].burst    = 2'b01;
   endtask

   task automatic randomRequest(int m);
      logic [31:0] a;
      a      = $urandom;
      a[5:4] = 2'(m);
      newRequest(m, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 7)));
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < N; i++)
         bus.ireqs[i] = reqs[i];
      bus.oresp = resp;
   endtask

   task automatic checkOutput(string tag);
      cbus_req_t  want_req;
      cbus_resp_t want_rsp;
      want_req = '0;
      if (owner >= 0) want_req = reqs[owner];
      checkEq({tag, ".oreq"}, 128'(bus.oreq), 128'(want_req));
      for (int i = 0; i < N; i++) begin
         want_rsp = '0;
         if (i == owner) want_rsp = resp;
         checkEq($sformatf("%s.iresps%0d", tag, i), 128'(bus.iresps[i]), 128'(want_rsp));
      end
   endtask

   task automatic tick(string tag);
      int w;
      if (rand_mode != 0)
         for (int i = 0; i < N; i++)
            if (!reqs[i].valid && $urandom_range(0, 3) == 0) randomRequest(i);
      resp      = '0;
      resp.data = {$urandom, $urandom};
      if (owner >= 0) begin
         resp.ready = (wait_mode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
         resp.last  = (ds_beat == int'(reqs[owner].len));
         resp.data  = 64'(ds_beat);
         if (resp.last && force_last_stall != 0) begin
            resp.ready       = 1'b0;
            force_last_stall = 0;
         end
         if (reqs[owner].is_write) reqs[owner].data = {$urandom, $urandom};
      end
      applyStimulus();
      #1;
      checkOutput(tag);
      for (int i = 0; i < N; i++)
         if (bus.iresps[i].ready === 1'b1) rx_beats[i]++;
      if (bus.oreq.valid === 1'b1 && prev_valid == 0) begin
         w = -1;
         for (int i = 0; i < N; i++)
            if (bus.oreq === reqs[i]) w = i;
         grant_log.push_back(w);
      end
      prev_valid = (bus.oreq.valid === 1'b1) ? 1 : 0;

      if (reset) begin
         owner      = -1;
         last_grant = N - 1;
         ds_beat    = 0;
         for (int i = 0; i < N; i++) rx_beats[i] = 0;
      end else if (owner < 0) begin
         w = pick();
         if (w >= 0) begin
            owner       = w;
            ds_beat     = 0;
            rx_beats[w] = 0;
         end
      end else if (resp.ready && resp.last) begin
         checkEq($sformatf("%s.beats%0d", tag, owner), 128'(rx_beats[owner]),
                 128'(int'(reqs[owner].len) + 1));
         done[owner] = 1;
         if (keep_alive != 0) randomRequest(owner);
         else reqs[owner].valid = 1'b0;
         last_grant = owner;
         owner      = -1;
      end else if (resp.ready) begin
         ds_beat++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clearDone();
      for (int i = 0; i < N; i++) done[i] = 0;
   endtask

   initial begin
      int exp_first;
      int cyc;
      for (int i = 0; i < N; i++) begin
         reqs[i]     = '0;
         rx_beats[i] = 0;
         done[i]     = 0;
      end
      resp = '0;
      owner = -1; last_grant = N - 1; ds_beat = 0;
      wait_mode = 0; keep_alive = 0; rand_mode = 0; force_last_stall = 0; prev_valid = 0;
      applyStimulus();
      reset = 1'b1;
      @(posedge clk);
      #1;
      tick("reset0");
      tick("reset1");
      reset = 1'b0;
      tick("idle");

      // Single 16-beat read from master 1
      clearDone();
      newRequest(1, 1'b0, 32'h8000_0040, MLEN16);
      for (cyc = 0; cyc < 60 && done[1] == 0; cyc++) tick("single");
      checkEq("single.done", 128'(done[1]), 128'(1));
      checkEq("single.grant", 128'(lastGrant()), 128'(1));
      tick("single.idle");

      // Short master-0 burst, then both masters request in the same cycle
      clearDone();
      newRequest(0, 1'b0, 32'h0000_1000, 4'd3);
      for (cyc = 0; cyc < 30 && done[0] == 0; cyc++) tick("prime");
      checkEq("prime.done", 128'(done[0]), 128'(1));
      clearDone();
      grant_log.delete();
      newRequest(0, 1'b0, 32'h0000_2000, 4'd4);
      newRequest(1, 1'b0, 32'h8000_0080, 4'd4);
      for (cyc = 0; cyc < 80 && (done[0] == 0 || done[1] == 0); cyc++) tick("simul");
      checkEq("simul.done", 128'(done[0] + done[1]), 128'(2));
`ifdef CBUS_ARB_RR_EN
      exp_first = 1;
`else
      exp_first = 0;
`endif
      checkEq("simul.count", 128'(grant_log.size()), 128'(2));
      if (grant_log.size() == 2) begin
         checkEq("simul.first", 128'(grant_log[0]), 128'(exp_first));
         checkEq("simul.second", 128'(grant_log[1]), 128'(1 - exp_first));
      end

      // Write burst with live data
      clearDone();
      newRequest(1, 1'b1, 32'h8000_0100, MLEN16);
      for (cyc = 0; cyc < 60 && done[1] == 0; cyc++) tick("write");
      checkEq("write.done", 128'(done[1]), 128'(1));

      // Wait states, including one last asserted without ready
      clearDone();
      wait_mode = 1;
      force_last_stall = 1;
      newRequest(0, 1'b0, 32'h0000_3000, MLEN16);
      for (cyc = 0; cyc < 300 && done[0] == 0; cyc++) tick("wait");
      checkEq("wait.done", 128'(done[0]), 128'(1));
      checkEq("wait.stall_used", 128'(force_last_stall), 128'(0));
      wait_mode = 0;
      force_last_stall = 0;

      // Reset in the middle of a burst
      clearDone();
      newRequest(1, 1'b0, 32'h8000_0200, MLEN16);
      for (cyc = 0; cyc < 40 && !(owner == 1 && ds_beat == 7); cyc++) tick("rst.run");
      checkEq("rst.reached_beat7", 128'(ds_beat), 128'(7));
      reset = 1'b1;
      tick("rst.assert");
      reset = 1'b0;
      reqs[1].valid = 1'b0;
      tick("rst.after");
      newRequest(0, 1'b0, 32'h0000_4000, 4'd2);
      for (cyc = 0; cyc < 30 && done[0] == 0; cyc++) tick("rst.regrant");
      checkEq("rst.regrant.done", 128'(done[0]), 128'(1));
      checkEq("rst.regrant.grant", 128'(lastGrant()), 128'(0));

      // Both masters continuously valid for six bursts
      grant_log.delete();
      keep_alive = 1;
      randomRequest(0);
      randomRequest(1);
      for (cyc = 0; cyc < 300 && grant_log.size() < 6; cyc++) tick("starve");
      keep_alive = 0;
      checkEq("starve.count", 128'(grant_log.size() >= 6), 128'(1));
      for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
`ifdef CBUS_ARB_RR_EN
         if (k > 0) checkEq($sformatf("starve.alt%0d", k), 128'(grant_log[k] != grant_log[k-1]), 128'(1));
         checkEq($sformatf("starve.id%0d", k), 128'(grant_log[k] >= 0), 128'(1));
`else
         checkEq($sformatf("starve.fixed%0d", k), 128'(grant_log[k]), 128'(0));
`endif
      end
      for (cyc = 0; cyc < 300 && (reqs[0].valid || reqs[1].valid || owner >= 0); cyc++) tick("starve.drain");
      checkEq("starve.drained", 128'(reqs[0].valid || reqs[1].valid), 128'(0));

      // Random traffic with wait states
      rand_mode = 1;
      wait_mode = 1;
      for (int c = 0; c < 400; c++) tick("rand");
      rand_mode = 0;
      for (cyc = 0; cyc < 400 && (reqs[0].valid || reqs[1].valid || owner >= 0); cyc++) tick("rand.drain");
      checkEq("rand.drained", 128'(reqs[0].valid || reqs[1].valid), 128'(0));
      wait_mode = 0;
      tick("final.idle");

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
